// File: rtl/midi_encoder_pkg.sv
// Shared encodings for the MIDI channel-message encoder: event kinds,
// status nibbles, FSM states and the status-byte builder.
package midi_encoder_pkg;

    typedef enum logic [1:0] {
        EV_NOTE_OFF    = 2'b00,
        EV_NOTE_ON     = 2'b01,
        EV_POLY_KEY    = 2'b10,
        EV_PITCH_WHEEL = 2'b11
    } ev_type_e;

    localparam logic [3:0] NIB_NOTE_OFF    = 4'h8;
    localparam logic [3:0] NIB_NOTE_ON     = 4'h9;
    localparam logic [3:0] NIB_POLY_KEY    = 4'hA;
    localparam logic [3:0] NIB_PITCH_WHEEL = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STATUS = 2'b01,
        ST_DATA1  = 2'b10,
        ST_DATA2  = 2'b11
    } state_e;

    function automatic logic [7:0] status_byte(input ev_type_e kind, input logic [3:0] chan);
        logic [3:0] nib;
        nib = NIB_NOTE_OFF;
        case (kind)
            EV_NOTE_OFF:    nib = NIB_NOTE_OFF;
            EV_NOTE_ON:     nib = NIB_NOTE_ON;
            EV_POLY_KEY:    nib = NIB_POLY_KEY;
            EV_PITCH_WHEEL: nib = NIB_PITCH_WHEEL;
            default:        nib = NIB_NOTE_OFF;
        endcase
        return {nib, chan};
    endfunction

endpackage

// File: rtl/midi_encoder.sv
// Serialises note/pitch-wheel events into 3-byte MIDI messages for a UART.
// Define RUNNING_STATUS_EN to omit repeated status bytes (bounded by STATUS_REFRESH).
module midi_encoder
    import midi_encoder_pkg::*;
#(
    parameter int STATUS_REFRESH = 16
) (
    input  logic       clk32,
    input  logic       rst,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic [1:0] ev_type,
    input  logic [3:0] channel,
    input  logic [6:0] note,
    input  logic [6:0] velocity,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready
);

`ifdef RUNNING_STATUS_EN
    localparam bit RS_EN = 1'b1;
`else
    localparam bit RS_EN = 1'b0;
`endif

    // Counter is one bit wider than needed so it can reach STATUS_REFRESH itself.
    localparam int              CNT_W       = $clog2(STATUS_REFRESH + 2);
    localparam logic [CNT_W-1:0] REFRESH_MAX = CNT_W'(STATUS_REFRESH);

    state_e           state_q, state_d;
    ev_type_e         type_q, type_d;
    logic [3:0]       channel_q, channel_d;
    logic [6:0]       note_q, note_d;
    logic [6:0]       vel_q, vel_d;
    logic [7:0]       last_status_q, last_status_d;
    logic             last_valid_q, last_valid_d;
    logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;

    logic [7:0] new_status;
    logic [7:0] cur_status;
    logic       accept;
    logic       skip_status;

    always_comb begin
        ev_ready = (state_q == ST_IDLE) && !rst;
        tx_valid = (state_q != ST_IDLE);
        tx_data  = 8'h00;
        case (state_q)
            ST_STATUS: tx_data = cur_status;
            ST_DATA1:  tx_data = {1'b0, note_q};
            ST_DATA2:  tx_data = {1'b0, vel_q};
            default:   tx_data = 8'h00;
        endcase
    end

    always_comb begin
        new_status  = status_byte(ev_type_e'(ev_type), channel);
        cur_status  = status_byte(type_q, channel_q);
        accept      = ev_valid && ev_ready;
        skip_status = RS_EN && last_valid_q && (new_status == last_status_q)
                      && (refresh_cnt_q < REFRESH_MAX);

        state_d       = state_q;
        type_d        = type_q;
        channel_d     = channel_q;
        note_d        = note_q;
        vel_d         = vel_q;
        last_status_d = last_status_q;
        last_valid_d  = last_valid_q;
        refresh_cnt_d = refresh_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    type_d    = ev_type_e'(ev_type);
                    channel_d = channel;
                    note_d    = note;
                    vel_d     = velocity;
                    if (skip_status) begin
                        state_d       = ST_DATA1;
                        refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
                    end else begin
                        state_d = ST_STATUS;
                    end
                end
            end
            ST_STATUS: begin
                // Running status tracks only status bytes actually handed to the UART.
                if (tx_ready) begin
                    state_d       = ST_DATA1;
                    last_status_d = cur_status;
                    last_valid_d  = 1'b1;
                    refresh_cnt_d = '0;
                end
            end
            ST_DATA1: begin
                if (tx_ready) state_d = ST_DATA2;
            end
            ST_DATA2: begin
                if (tx_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk32) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            type_q        <= EV_NOTE_OFF;
            channel_q     <= 4'h0;
            note_q        <= 7'h00;
            vel_q         <= 7'h00;
            last_status_q <= 8'h00;
            last_valid_q  <= 1'b0;
            refresh_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            channel_q     <= channel_d;
            note_q        <= note_d;
            vel_q         <= vel_d;
            last_status_q <= last_status_d;
            last_valid_q  <= last_valid_d;
            refresh_cnt_q <= refresh_cnt_d;
        end
    end

endmodule

// File: tb/tb_midi_encoder.sv
// Directed self-checking bench for midi_encoder; expectations follow
// RUNNING_STATUS_EN when the bench is built with that macro.
module tb_midi_encoder;
    import midi_encoder_pkg::*;

    logic       clk32 = 1'b0;
    logic       rst;
    logic       ev_valid;
    logic       ev_ready;
    logic [1:0] ev_type;
    logic [3:0] channel;
    logic [6:0] note;
    logic [6:0] velocity;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk32 = ~clk32;

    midi_encoder #(.STATUS_REFRESH(2)) dut (
        .clk32    (clk32),
        .rst      (rst),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_type  (ev_type),
        .channel  (channel),
        .note     (note),
        .velocity (velocity),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

    task automatic step();
        @(posedge clk32);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] t, input logic [3:0] ch,
                                 input logic [6:0] n, input logic [6:0] vel);
        ev_valid = v;
        ev_type  = t;
        channel  = ch;
        note     = n;
        velocity = vel;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic checkByte(input string tag, input logic [7:0] exp);
        checkOutput({tag, "_valid"}, {7'b0, tx_valid}, 8'h01);
        checkOutput(tag, tx_data, exp);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_txv"}, {7'b0, tx_valid}, 8'h00);
        checkOutput({tag, "_txd"}, tx_data, 8'h00);
        checkOutput({tag, "_rdy"}, {7'b0, ev_ready}, 8'h01);
    endtask

    initial begin
        logic [7:0] expq[$];
        logic [1:0] evt[3];
        logic [6:0] evn[3];
        logic [6:0] evv[3];
        bit         send_status[4];
        int         idx;
        int         k;
        int         cyc;
        bit         done;
        bit         acc;

        rst      = 1'b1;
        tx_ready = 1'b1;
        applyStimulus(1'b0, 2'b00, 4'h0, 7'h00, 7'h00);
        step();
        step();
        checkOutput("rst_txv", {7'b0, tx_valid}, 8'h00);
        checkOutput("rst_txd", tx_data, 8'h00);
        checkOutput("rst_rdy", {7'b0, ev_ready}, 8'h00);
        rst = 1'b0;
        step();
        checkIdle("post_rst");

        // Note-on ch3 60/100: bytes in N+1..N+3, ready again in N+4
        applyStimulus(1'b1, 2'b01, 4'd3, 7'd60, 7'd100);
        step();
        ev_valid = 1'b0;
        checkByte("non_status", 8'h93);
        checkOutput("non_busy_rdy", {7'b0, ev_ready}, 8'h00);
        step();
        checkByte("non_d1", 8'h3C);
        step();
        checkByte("non_d2", 8'h64);
        step();
        checkIdle("non_end");

        // Pitch wheel ch0 with a 5-cycle stall in DATA1
        applyStimulus(1'b1, 2'b11, 4'd0, 7'h00, 7'h40);
        step();
        ev_valid = 1'b0;
        checkByte("pw_status", 8'hE0);
        step();
        for (int i = 0; i < 5; i++) begin
            tx_ready = 1'b0;
            checkByte("pw_stall", 8'h00);
            step();
        end
        tx_ready = 1'b1;
        checkByte("pw_d1", 8'h00);
        step();
        checkByte("pw_d2", 8'h40);
        step();
        checkIdle("pw_end");

        applyStimulus(1'b1, 2'b10, 4'd15, 7'h7F, 7'h01);
        step();
        ev_valid = 1'b0;
        checkByte("pk_status", 8'hAF);
        step();
        checkByte("pk_d1", 8'h7F);
        step();
        checkByte("pk_d2", 8'h01);
        step();
        checkIdle("pk_end");

        // Velocity-0 note-on stays a note-on
        applyStimulus(1'b1, 2'b01, 4'd2, 7'h40, 7'h00);
        step();
        ev_valid = 1'b0;
        checkByte("v0_status", 8'h92);
        step();
        checkByte("v0_d1", 8'h40);
        step();
        checkByte("v0_d2", 8'h00);
        step();
        checkIdle("v0_end");

        applyStimulus(1'b1, 2'b00, 4'd1, 7'h10, 7'h20);
        step();
        ev_valid = 1'b0;
        checkByte("nof_status", 8'h81);
        step();
        checkByte("nof_d1", 8'h10);
        step();
        checkByte("nof_d2", 8'h20);
        step();
        checkIdle("nof_end");

        // Four held note-ons on ch1, one idle cycle between messages
`ifdef RUNNING_STATUS_EN
        send_status = '{1'b1, 1'b0, 1'b0, 1'b1};
`else
        send_status = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        applyStimulus(1'b1, 2'b01, 4'd1, 7'h3C, 7'h50);
        step();
        for (int m = 0; m < 4; m++) begin
            if (m == 3) ev_valid = 1'b0;
            if (send_status[m]) begin
                checkByte("rs_status", 8'h91);
                step();
            end
            checkByte("rs_d1", 8'h3C);
            step();
            checkByte("rs_d2", 8'h50);
            step();
            checkIdle("rs_gap");
            if (m < 3) step();
        end

        applyStimulus(1'b1, 2'b00, 4'd1, 7'h3C, 7'h50);
        step();
        ev_valid = 1'b0;
        checkByte("rs_off_status", 8'h81);
        step();
        checkByte("rs_off_d1", 8'h3C);
        step();
        checkByte("rs_off_d2", 8'h50);
        step();
        checkIdle("rs_off_end");

        // Reset during DATA1 aborts the message
        applyStimulus(1'b1, 2'b00, 4'd4, 7'h11, 7'h22);
        step();
        ev_valid = 1'b0;
        checkByte("ab_status", 8'h84);
        step();
        checkByte("ab_d1", 8'h11);
        rst = 1'b1;
        step();
        checkOutput("ab_txv", {7'b0, tx_valid}, 8'h00);
        checkOutput("ab_txd", tx_data, 8'h00);
        checkOutput("ab_rdy", {7'b0, ev_ready}, 8'h00);
        rst = 1'b0;
        step();
        checkIdle("ab_idle");
        applyStimulus(1'b1, 2'b01, 4'd4, 7'h11, 7'h22);
        step();
        ev_valid = 1'b0;
        checkByte("ab_new_status", 8'h94);
        step();
        checkByte("ab_new_d1", 8'h11);
        step();
        checkByte("ab_new_d2", 8'h22);
        step();
        checkIdle("ab_new_end");

        // Three queued events with random tx_ready back-pressure
        evt = '{2'b01, 2'b01, 2'b11};
        evn = '{7'h11, 7'h33, 7'h00};
        evv = '{7'h22, 7'h44, 7'h7F};
`ifdef RUNNING_STATUS_EN
        expq = '{8'h95, 8'h11, 8'h22, 8'h33, 8'h44, 8'hE5, 8'h00, 8'h7F};
`else
        expq = '{8'h95, 8'h11, 8'h22, 8'h95, 8'h33, 8'h44, 8'hE5, 8'h00, 8'h7F};
`endif
        idx  = 0;
        k    = 0;
        cyc  = 0;
        done = 1'b0;
        applyStimulus(1'b1, evt[0], 4'd5, evn[0], evv[0]);
        while (!done && cyc < 300) begin
            tx_ready = 1'($urandom_range(0, 1));
            checkOutput("rnd_rdy_outside_idle", {7'b0, ev_ready & tx_valid}, 8'h00);
            if (tx_valid && tx_ready) begin
                if (k < expq.size()) checkOutput("rnd_stream", tx_data, expq[k]);
                else checkOutput("rnd_stream_overrun", 8'(k + 1), 8'(expq.size()));
                k++;
            end
            acc = ev_valid && ev_ready;
            step();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 3) applyStimulus(1'b1, evt[idx], 4'd5, evn[idx], evv[idx]);
                else ev_valid = 1'b0;
            end
            if (k >= expq.size() && idx >= 3 && !tx_valid) done = 1'b1;
        end
        tx_ready = 1'b1;
        checkOutput("rnd_timeout", {7'b0, done}, 8'h01);
        checkOutput("rnd_len", 8'(k), 8'(expq.size()));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
